// File: rtl/dataflow_pkg.sv
// Shared definitions for the LEGv8 dataflow controller: opcodes, instruction
// field positions, FSM state encoding and the decoded control bundle.
package dataflow_pkg;

    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;

    // Instruction field bit positions (R and D formats share Rn/Rt positions)
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 21;
    localparam int RM_MSB  = 20;
    localparam int RM_LSB  = 16;
    localparam int IMM_MSB = 20;
    localparam int IMM_LSB = 12;
    localparam int RN_MSB  = 9;
    localparam int RN_LSB  = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 0;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic legal;
        logic is_load;
        logic is_store;
        logic alu_sub;
        logic sel_b;
        logic sel_wb;
    } dec_t;

endpackage

// File: rtl/decodificador.sv
// Combinational opcode decoder producing the per-instruction control bundle.
module decodificador
    import dataflow_pkg::*;
(
    input  logic [10:0] i_opcode,
    output dec_t        o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        unique case (i_opcode)
            OPC_ADD: begin
                o_ctrl.legal  = 1'b1;
                o_ctrl.sel_b  = 1'b1;
                o_ctrl.sel_wb = 1'b1;
            end
            OPC_SUB: begin
                o_ctrl.legal   = 1'b1;
                o_ctrl.alu_sub = 1'b1;
                o_ctrl.sel_b   = 1'b1;
                o_ctrl.sel_wb  = 1'b1;
            end
            OPC_LDUR: begin
                o_ctrl.legal   = 1'b1;
                o_ctrl.is_load = 1'b1;
            end
            OPC_STUR: begin
                o_ctrl.legal    = 1'b1;
                o_ctrl.is_store = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/controle_dataflow.sv
// Multi-cycle LEGv8 controller: accepts one instruction at a time and sequences
// register-file read, ALU, data-memory and writeback control for ADD/SUB/LDUR/STUR.
module controle_dataflow
    import dataflow_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [4:0]        ra,
    output logic [4:0]        rb,
    output logic [4:0]        rw,
    output logic              reg_we,
    output logic              mem_we,
    output logic              alu_sub,
    output logic              sel_b,
    output logic              sel_wb,
    output logic [DATA_W-1:0] imm,
    output logic              done,
    output logic              err
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instr;
    logic        r_alive;
    dec_t        w_dec;
    logic        w_accept;
    logic        w_dtype;
    logic [4:0]  w_rd;

    decodificador u_dec (
        .i_opcode (r_instr[OPC_MSB:OPC_LSB]),
        .o_ctrl   (w_dec)
    );

    // r_alive keeps instr_ready low until the first edge after reset release
    assign w_accept = (r_state == ST_IDLE) && r_alive && instr_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_instr <= '0;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_next;
            r_alive <= 1'b1;
            if (w_accept) begin
                r_instr <= instr;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_READ;
            ST_READ: w_next = w_dec.legal ? ST_EXEC : ST_ERR;
            ST_EXEC: w_next = (w_dec.is_load || w_dec.is_store) ? ST_MEM : ST_WB;
            ST_MEM:  w_next = w_dec.is_load ? ST_WB : ST_IDLE;
            ST_WB:   w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_dtype = w_dec.is_load || w_dec.is_store;
    assign w_rd    = r_instr[RD_MSB:RD_LSB];

    assign ra = r_instr[RN_MSB:RN_LSB];
    assign rw = w_rd;
    assign rb = w_dtype ? w_rd : r_instr[RM_MSB:RM_LSB];

    // The memory address comes from the adder, so it must fit in a datapath word
    generate
        if (DATA_W > 9 && ADDR_W <= DATA_W) begin : g_imm
            assign imm = {{(DATA_W-9){r_instr[IMM_MSB]}}, r_instr[IMM_MSB:IMM_LSB]};
        end else begin : g_imm_none
            assign imm = '0;
        end
    endgenerate

    always_comb begin
        instr_ready = 1'b0;
        reg_we      = 1'b0;
        mem_we      = 1'b0;
        alu_sub     = 1'b0;
        sel_b       = 1'b0;
        sel_wb      = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        unique case (r_state)
            ST_IDLE: instr_ready = r_alive;
            ST_READ: ;
            ST_EXEC: begin
                alu_sub = w_dec.alu_sub;
                sel_b   = w_dec.sel_b;
            end
            ST_MEM: begin
                alu_sub = w_dec.alu_sub;
                sel_b   = w_dec.sel_b;
                mem_we  = w_dec.is_store;
                done    = w_dec.is_store;
            end
            ST_WB: begin
                alu_sub = w_dec.alu_sub;
                sel_b   = w_dec.sel_b;
                sel_wb  = w_dec.sel_wb;
                reg_we  = (w_rd != XZR);
                done    = 1'b1;
            end
            ST_ERR: err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controle_dataflow.sv
// Self-checking bench for controle_dataflow: directed vectors plus random
// instructions compared cycle by cycle against a per-instruction schedule model.
module tb_controle_dataflow;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [4:0]        ra, rb, rw;
    logic              reg_we, mem_we, alu_sub, sel_b, sel_wb;
    logic [DATA_W-1:0] imm;
    logic              done, err;

    int total = 0;
    int bad   = 0;

    logic [7:0]  obsCtrl;
    logic [78:0] obsFields;

    controle_dataflow #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ra          (ra),
        .rb          (rb),
        .rw          (rw),
        .reg_we      (reg_we),
        .mem_we      (mem_we),
        .alu_sub     (alu_sub),
        .sel_b       (sel_b),
        .sel_wb      (sel_wb),
        .imm         (imm),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    assign obsCtrl   = {instr_ready, reg_we, mem_we, alu_sub, sel_b, sel_wb, done, err};
    assign obsFields = {ra, rb, rw, imm};

    // Instruction kinds: 0 ADD, 1 SUB, 2 LDUR, 3 STUR, 4 illegal
    function automatic int kindOf(input logic [31:0] w);
        case (w[31:21])
            11'h458: return 0;
            11'h658: return 1;
            11'h7C2: return 2;
            11'h7C0: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int latencyOf(input int kd);
        case (kd)
            2:       return 4;
            4:       return 2;
            default: return 3;
        endcase
    endfunction

    // Cycle k after accept: 1 read, 2 exec, 3 mem, 4 writeback, 5 error
    function automatic int stageOf(input int kd, input int k);
        if (k == 1) return 1;
        if (kd == 4) return 5;
        if (k == 2) return 2;
        if (kd <= 1) return 4;
        if (k == 3) return 3;
        return 4;
    endfunction

    // Bit order: ready, reg_we, mem_we, alu_sub, sel_b, sel_wb, done, err
    function automatic logic [7:0] expCtrl(input logic [31:0] w, input int k);
        int   kd    = kindOf(w);
        int   st    = stageOf(kd, k);
        logic arith = (kd <= 1);
        logic sub   = (kd == 1);
        logic [7:0] e = '0;
        if (st == 2 || st == 3 || st == 4) begin
            e[4] = sub;
            e[3] = arith;
        end
        if (st == 3 && kd == 3) begin
            e[5] = 1'b1;
            e[1] = 1'b1;
        end
        if (st == 4) begin
            e[2] = arith;
            e[6] = (w[4:0] != 5'd31);
            e[1] = 1'b1;
        end
        if (st == 5) e[0] = 1'b1;
        return e;
    endfunction

    function automatic logic [78:0] expFields(input logic [31:0] w);
        int kd = kindOf(w);
        int v  = int'(w[20:12]);
        logic [4:0]  rbE;
        logic [63:0] immE;
        if (v >= 256) v = v - 512;
        immE = 64'(longint'(v));
        rbE  = (kd == 2 || kd == 3) ? w[4:0] : w[20:16];
        return {w[9:5], rbE, w[4:0], immE};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offers w in IDLE and follows it to retirement with valid held high and
    // garbage instruction words on the bus while busy.
    task automatic applyStimulus(input string name, input logic [31:0] w);
        int len = latencyOf(kindOf(w));
        instr       = w;
        instr_valid = 1'b1;
        @(negedge clk);
        checkOutput({name, " idle"}, 128'(obsCtrl), 128'(8'h80));
        @(posedge clk); #1;
        for (int k = 1; k <= len; k++) begin
            instr = $urandom;
            @(negedge clk);
            checkOutput($sformatf("%s ctrl c%0d", name, k), 128'(obsCtrl), 128'(expCtrl(w, k)));
            if (kindOf(w) != 4)
                checkOutput($sformatf("%s fields c%0d", name, k), 128'(obsFields), 128'(expFields(w)));
            @(posedge clk); #1;
        end
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, " ctrl"}, 128'(obsCtrl), 128'(0));
        checkOutput({name, " fields"}, 128'(obsFields), 128'(0));
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 4))
            0: w[31:21] = 11'h458;
            1: w[31:21] = 11'h658;
            2: w[31:21] = 11'h7C2;
            3: w[31:21] = 11'h7C0;
            default: w[31:21] = 11'($urandom);
        endcase
        if ($urandom_range(0, 3) == 0) w[4:0] = 5'd31;
        return w;
    endfunction

    initial begin
        rst_n       = 1'b0;
        instr       = 32'h8B020023;
        instr_valid = 1'b1;
        #12;
        checkResetState("reset");
        @(posedge clk); #1;
        checkResetState("reset held");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready before edge", 128'(instr_ready), 128'(0));
        @(posedge clk); #1;
        checkOutput("ready after edge", 128'(instr_ready), 128'(1));

        applyStimulus("add", 32'h8B020023);
        applyStimulus("sub", 32'hCB020023);
        applyStimulus("ldur", 32'hF8401005);
        applyStimulus("stur", 32'hF81FE001);
        applyStimulus("illegal", 32'h00000000);
        applyStimulus("add xzr", 32'h8B02003F);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                instr_valid = 1'b0;
                instr       = $urandom;
                @(negedge clk);
                checkOutput("gap idle", 128'(obsCtrl), 128'(8'h80));
                @(posedge clk); #1;
            end
            applyStimulus($sformatf("rand%0d", i), randInstr());
        end

        // Abort an LDUR while it sits in the memory stage
        instr       = 32'hF8401005;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("ldur mem before reset", 128'(obsCtrl), 128'(expCtrl(32'hF8401005, 3)));
        #2 rst_n = 1'b0;
        #1;
        checkResetState("abort reset");
        @(posedge clk); #1;
        checkResetState("abort no wb");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort ready before edge", 128'(instr_ready), 128'(0));
        @(posedge clk); #1;
        checkOutput("abort ready after edge", 128'(instr_ready), 128'(1));
        applyStimulus("post reset add", 32'h8B020023);
        instr_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
